// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller: 8-bit CPU port in front of a
// block-organised memory, with write-back and refill sequencing on a miss.
module dcache_ctrl #(
  parameter int  INDEX_W  = 3,
  parameter int  OFFSET_W = 2,
  localparam int TAG_W    = 8 - INDEX_W - OFFSET_W,
  localparam int MA_W     = 8 - OFFSET_W,
  localparam int BLK_W    = 8 * (2 ** OFFSET_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read,
  input  logic             write,
  input  logic [7:0]       address,
  input  logic [7:0]       writedata,
  output logic [7:0]       readdata,
  output logic             busywait,
  output logic             mem_read,
  output logic             mem_write,
  output logic [MA_W-1:0]  mem_address,
  output logic [BLK_W-1:0] mem_writedata,
  input  logic [BLK_W-1:0] mem_readdata,
  input  logic             mem_busywait
);

  localparam int LINES = 2 ** INDEX_W;

  typedef enum logic [1:0] {IDLE, WB, FETCH, UPDATE} state_e;

  state_e              state_q, state_d;
  logic [BLK_W-1:0]    line_q [LINES];
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;
  logic [BLK_W-1:0]    fill_q, fill_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [MA_W-1:0]     mem_address_q, mem_address_d;
  logic [BLK_W-1:0]    mem_writedata_q, mem_writedata_d;
  logic [7:0]          readdata_q, readdata_d;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic [TAG_W-1:0]    upd_tag;
  logic [INDEX_W-1:0]  upd_idx;
  logic                hit, idle_hit, read_hit, write_hit;

  assign req_tag = address[7 -: TAG_W];
  assign req_idx = address[OFFSET_W +: INDEX_W];
  assign req_off = address[OFFSET_W-1:0];
  // The refill target comes from the registered block address, so a request
  // dropped mid-sequence still installs the line it asked for.
  assign upd_tag = mem_address_q[MA_W-1 -: TAG_W];
  assign upd_idx = mem_address_q[INDEX_W-1:0];

  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign idle_hit  = (state_q == IDLE) && hit;
  assign write_hit = write && idle_hit;
  assign read_hit  = read && !write && idle_hit;

  assign busywait      = (read || write) && !idle_hit;
  assign readdata_d    = read_hit ? line_q[req_idx][{req_off, 3'b000} +: 8] : readdata_q;
  assign readdata      = readdata_d;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    dirty_d         = dirty_q;
    fill_d          = fill_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    case (state_q)
      IDLE: begin
        if ((read || write) && !hit) begin
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WB : FETCH;
        end
      end
      WB: begin
        if (!mem_busywait) state_d = FETCH;
      end
      FETCH: begin
        if (!mem_busywait) begin
          state_d = UPDATE;
          fill_d  = mem_readdata;
        end
      end
      UPDATE: begin
        state_d          = IDLE;
        valid_d[upd_idx] = 1'b1;
        dirty_d[upd_idx] = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (write_hit) dirty_d[req_idx] = 1'b1;
    // Memory strobes are decoded from the next state so they are registered.
    mem_write_d = (state_d == WB);
    mem_read_d  = (state_d == FETCH);
    if (state_q == IDLE && state_d == WB) begin
      mem_address_d   = {tag_q[req_idx], req_idx};
      mem_writedata_d = line_q[req_idx];
    end
    if (state_q != FETCH && state_d == FETCH) begin
      mem_address_d = {req_tag, req_idx};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      dirty_q         <= '0;
      fill_q          <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      readdata_q      <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      dirty_q         <= dirty_d;
      fill_q          <= fill_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      readdata_q      <= readdata_d;
    end
  end

  // Line data and tags carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state_q == UPDATE) begin
      line_q[upd_idx] <= fill_q;
      tag_q[upd_idx]  <= upd_tag;
    end else if (write_hit) begin
      line_q[req_idx][{req_off, 3'b000} +: 8] <= writedata;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a flat byte-memory view of what the CPU
// must observe, plus a per-line tag/valid/dirty model predicting stalls.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0, write = 1'b0;
  logic [7:0]  address = '0, writedata = '0;
  logic [7:0]  readdata;
  logic        busywait, mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        mem_busywait = 1'b1;

  dcache_ctrl #(.INDEX_W(3), .OFFSET_W(2)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Backing memory and the coherent CPU-visible byte view.
  logic [31:0] bmem [64];
  logic [7:0]  ref_mem [256];
  bit          mvalid [8];
  bit          mdirty [8];
  logic [2:0]  mtag [8];
  logic [7:0]  exp_rd;
  int          dly = 1;

  logic [5:0]  last_wb_addr, last_fetch_addr;
  logic [31:0] last_wb_data;
  int          last_stall;
  bit          saw_wb;

  // Slow memory: busy for dly cycles of a request, then one low cycle.
  int cnt = 0;
  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      cnt++;
      if (cnt >= dly) begin
        if (mem_read)  mem_readdata = bmem[mem_address];
        if (mem_write) bmem[mem_address] = mem_writedata;
        cnt = 0;
        mem_busywait = 1'b0;
      end else begin
        mem_busywait = 1'b1;
      end
    end else begin
      cnt = 0;
      mem_busywait = 1'b1;
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rst) chk("strobe_mutex", {31'd0, mem_read && mem_write}, 32'd0);
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    for (int a = 0; a < 256; a++) ref_mem[a] = bmem[a >> 2][8*(a % 4) +: 8];
    exp_rd = 8'h00;
  endtask

  task automatic op(input bit rd, input bit wr, input logic [7:0] a,
                    input logic [7:0] wd, input int d);
    logic [2:0]  idx, tg;
    logic [5:0]  oblk;
    logic [31:0] old_blk;
    bit          hit, wbexp;
    int          stall, wbc, fc, exp_stall;
    idx = a[4:2];
    tg  = a[7:5];
    stall = 0; wbc = 0; fc = 0;
    dly = d;
    @(negedge clk);
    read = rd; write = wr; address = a; writedata = wd;
    #1;
    hit   = mvalid[idx] && (mtag[idx] == tg);
    wbexp = !hit && mvalid[idx] && mdirty[idx];
    oblk  = {mtag[idx], idx};
    old_blk = {ref_mem[{oblk, 2'd3}], ref_mem[{oblk, 2'd2}],
               ref_mem[{oblk, 2'd1}], ref_mem[{oblk, 2'd0}]};
    while (busywait && stall < 40) begin
      stall++;
      if (mem_write) begin
        if (wbc == 0) begin
          chk("wb_addr", {26'd0, mem_address}, {26'd0, oblk});
          chk("wb_data", mem_writedata, old_blk);
          last_wb_addr = mem_address;
          last_wb_data = mem_writedata;
        end
        wbc++;
      end
      if (mem_read) begin
        if (fc == 0) begin
          chk("fetch_addr", {26'd0, mem_address}, {26'd0, tg, idx});
          last_fetch_addr = mem_address;
        end
        fc++;
      end
      @(negedge clk);
      #1;
    end
    // One decision cycle in IDLE, the memory phases, then one install cycle.
    exp_stall = hit ? 0 : (2 + d + (wbexp ? d : 0));
    chk("stall_cycles", stall, exp_stall);
    chk("wb_cycles", wbc, wbexp ? d : 0);
    chk("fetch_cycles", fc, hit ? 0 : d);
    if (!hit) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      mdirty[idx] = 1'b0;
    end
    if (rd && !wr) exp_rd = ref_mem[a];
    chk("readdata", {24'd0, readdata}, {24'd0, exp_rd});
    if (wr) begin
      ref_mem[a]  = wd;
      mdirty[idx] = 1'b1;
    end
    last_stall = stall;
    saw_wb     = (wbc > 0);
    @(negedge clk);
    read = 1'b0; write = 1'b0; address = 8'($urandom);
    #1;
    chk("readdata_hold", {24'd0, readdata}, {24'd0, exp_rd});
  endtask

  initial begin
    int w;
    for (int i = 0; i < 64; i++) bmem[i] = $urandom;
    bmem[1] = 32'hDDCCBBAA;
    bmem[9] = 32'h11223344;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_address", {26'd0, mem_address}, 32'd0);
    chk("rst_mem_writedata", mem_writedata, 32'd0);
    chk("rst_readdata", {24'd0, readdata}, 32'd0);
    chk("rst_busywait", {31'd0, busywait}, 32'd0);
    rst = 1'b0;

    op(1, 0, 8'h05, 8'h00, 5);
    chk("t1_fetch_addr", {26'd0, last_fetch_addr}, 32'h01);
    chk("t1_readdata", {24'd0, readdata}, 32'hBB);
    chk("t1_stall", last_stall, 7);
    op(1, 0, 8'h04, 8'h00, 3);
    chk("t2_readdata", {24'd0, readdata}, 32'hAA);
    chk("t2_stall", last_stall, 0);
    op(0, 1, 8'h07, 8'h5A, 3);
    chk("t3_write_stall", last_stall, 0);
    op(1, 0, 8'h07, 8'h00, 3);
    chk("t3_readback", {24'd0, readdata}, 32'h5A);
    op(1, 0, 8'h27, 8'h00, 4);
    chk("t3_wb_addr", {26'd0, last_wb_addr}, 32'h01);
    chk("t3_wb_data", last_wb_data, 32'h5ACCBBAA);
    chk("t3_fetch_addr", {26'd0, last_fetch_addr}, 32'h09);
    chk("t3_readdata", {24'd0, readdata}, 32'h11);
    chk("t3_stall", last_stall, 10);
    op(1, 0, 8'h47, 8'h00, 2);
    chk("t4_clean_no_wb", {31'd0, saw_wb}, 32'd0);
    chk("t4_stall", last_stall, 4);

    // Asynchronous reset while the refill is outstanding.
    dly = 6;
    @(negedge clk);
    read = 1'b1; address = 8'h05;
    repeat (3) @(negedge clk);
    #1;
    chk("t5_in_fetch", {31'd0, mem_read}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_mem_read", {31'd0, mem_read}, 32'd0);
    chk("t5_async_readdata", {24'd0, readdata}, 32'd0);
    chk("t5_miss_after_rst", {31'd0, busywait}, 32'd1);
    rst = 1'b0;
    read = 1'b0;
    model_reset();
    op(1, 0, 8'h05, 8'h00, 2);
    chk("t5_remiss_stall", last_stall, 4);
    chk("t5_readdata", {24'd0, readdata}, 32'hBB);

    op(1, 0, 8'h04, 8'h00, 2);
    chk("t6_pre_read", {24'd0, readdata}, 32'hAA);
    op(1, 1, 8'h04, 8'h77, 2);
    chk("t6_both_stall", last_stall, 0);
    chk("t6_read_ignored", {24'd0, readdata}, 32'hAA);
    op(1, 0, 8'h04, 8'h00, 2);
    chk("t6_written", {24'd0, readdata}, 32'h77);
    op(1, 0, 8'h24, 8'h00, 3);
    chk("t6_dirty_wb", {31'd0, saw_wb}, 32'd1);
    chk("t6_wb_data", last_wb_data, 32'h5ACCBB77);

    // Request withdrawn mid-refill: the line must still be installed.
    dly = 3;
    @(negedge clk);
    read = 1'b1; address = 8'h65;
    repeat (2) @(negedge clk);
    read = 1'b0;
    w = 0;
    while (mem_read && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("t7_refill_done", {31'd0, mem_read}, 32'd0);
    mvalid[1] = 1'b1; mtag[1] = 3'd3; mdirty[1] = 1'b0;
    repeat (2) @(negedge clk);
    op(1, 0, 8'h65, 8'h00, 3);
    chk("t7_installed_hit", last_stall, 0);

    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [7:0] a;
      a    = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      kind = $urandom_range(0, 9);
      op(kind < 5 || kind == 9, kind >= 5, a, 8'($urandom), $urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
